// File: rtl/writeback_queue.sv
// In-order register-file writeback queue merging ALU/load (port A) and multdiv (port B) writes.
// The head entry is written every non-empty cycle; query_pending flags registers with a queued write.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          a_valid,
    input  logic [4:0]    a_reg,
    input  logic [31:0]   a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [4:0]    b_reg,
    input  logic [31:0]   b_data,
    output logic          b_ready,
    output logic          ctrl_writeEN,
    output logic [4:0]    ctrl_writeReg,
    output logic [31:0]   data_writeReg,
    input  logic [4:0]    query_reg,
    output logic          query_pending,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [4:0]    reg_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] b_slot;
    logic          pop;
    logic          a_enq;
    logic          b_enq;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = ~empty;

    // Readiness uses only the registered count so it never depends on the pop.
    assign a_ready = ~full;
    assign a_enq   = a_valid & a_ready & (a_reg != 5'd0);
    assign b_ready = (count <= CW'(DEPTH - 2)) | (~full & ~a_enq);
    assign b_enq   = b_valid & b_ready & (b_reg != 5'd0);
    assign b_slot  = wptr + PW'(a_enq);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + PW'(pop);
            wptr  <= wptr + PW'(a_enq) + PW'(b_enq);
            count <= count + CW'(a_enq) + CW'(b_enq) - CW'(pop);
        end
    end

    // Storage needs no reset; only slots covered by count are ever observed.
    always_ff @(posedge clock) begin
        if (a_enq) begin
            reg_mem[wptr]  <= a_reg;
            data_mem[wptr] <= a_data;
        end
        if (b_enq) begin
            reg_mem[b_slot]  <= b_reg;
            data_mem[b_slot] <= b_data;
        end
    end

    always_comb begin
        ctrl_writeEN  = pop;
        ctrl_writeReg = 5'd0;
        data_writeReg = 32'd0;
        if (pop) begin
            ctrl_writeReg = reg_mem[rptr];
            data_writeReg = data_mem[rptr];
        end
    end

    // Scan the occupied slots, starting from the head, for a matching destination.
    always_comb begin
        logic [PW-1:0] slot;
        query_pending = 1'b0;
        slot          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rptr + PW'(i);
            if ((CW'(i) < count) && (reg_mem[slot] == query_reg) && (query_reg != 5'd0))
                query_pending = 1'b1;
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_writeback_queue;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clock;
    logic          ctrl_reset;
    logic          a_valid;
    logic [4:0]    a_reg;
    logic [31:0]   a_data;
    logic          a_ready;
    logic          b_valid;
    logic [4:0]    b_reg;
    logic [31:0]   b_data;
    logic          b_ready;
    logic          ctrl_writeEN;
    logic [4:0]    ctrl_writeReg;
    logic [31:0]   data_writeReg;
    logic [4:0]    query_reg;
    logic          query_pending;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .ctrl_writeEN(ctrl_writeEN), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .query_reg(query_reg), .query_pending(query_pending),
        .count(count), .full(full), .empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    entry_t model_q[$];
    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] br, input logic [31:0] bd);
        @(posedge clock);
        #1;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
    endtask

    // Mid-cycle comparison against the model, then advance the model across the coming edge.
    always @(negedge clock) begin : compare
        int     free;
        logic   exp_a_rdy, exp_b_rdy, a_take, b_take, exp_q;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        entry_t e;
        if (ctrl_reset) model_q.delete();
        free      = DEPTH - model_q.size();
        exp_a_rdy = (free >= 1);
        a_take    = a_valid && exp_a_rdy && (a_reg != 5'd0);
        exp_b_rdy = (free >= 2) || ((free >= 1) && !a_take);
        b_take    = b_valid && exp_b_rdy && (b_reg != 5'd0);
        exp_q     = 1'b0;
        foreach (model_q[i])
            if (query_reg != 5'd0 && model_q[i].r == query_reg) exp_q = 1'b1;
        exp_reg  = 5'd0;
        exp_data = 32'd0;
        if (model_q.size() > 0) begin
            exp_reg  = model_q[0].r;
            exp_data = model_q[0].d;
        end
        checkOutput("writeEN", 32'(ctrl_writeEN), 32'(model_q.size() > 0));
        checkOutput("writeReg", 32'(ctrl_writeReg), 32'(exp_reg));
        checkOutput("writeData", data_writeReg, exp_data);
        checkOutput("count", 32'(count), 32'(model_q.size()));
        checkOutput("full", 32'(full), 32'(model_q.size() == DEPTH));
        checkOutput("empty", 32'(empty), 32'(model_q.size() == 0));
        checkOutput("a_ready", 32'(a_ready), 32'(exp_a_rdy));
        checkOutput("b_ready", 32'(b_ready), 32'(exp_b_rdy));
        checkOutput("query_pending", 32'(query_pending), 32'(exp_q));
        if (!ctrl_reset) begin
            if (model_q.size() > 0) void'(model_q.pop_front());
            if (a_take) begin e.r = a_reg; e.d = a_data; model_q.push_back(e); end
            if (b_take) begin e.r = b_reg; e.d = b_data; model_q.push_back(e); end
        end
    end

    initial begin
        int next_reg;
        ctrl_reset = 1'b1;
        a_valid = 0; a_reg = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_data = 0;
        query_reg = 0;

        // Outputs while reset is held.
        repeat (2) @(posedge clock);
        #2;
        checkOutput("rst_writeEN", 32'(ctrl_writeEN), 32'd0);
        checkOutput("rst_writeReg", 32'(ctrl_writeReg), 32'd0);
        checkOutput("rst_writeData", data_writeReg, 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_a_ready", 32'(a_ready), 32'd1);
        checkOutput("rst_b_ready", 32'(b_ready), 32'd1);
        @(posedge clock);
        #1 ctrl_reset = 1'b0;
        repeat (2) @(posedge clock);

        // Single A write, visible for exactly one cycle.
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(negedge clock); #1;
        checkOutput("single_writeEN", 32'(ctrl_writeEN), 32'd1);
        checkOutput("single_writeReg", 32'(ctrl_writeReg), 32'd5);
        checkOutput("single_writeData", data_writeReg, 32'hDEADBEEF);
        @(negedge clock); #1;
        checkOutput("single_empty_after", 32'(empty), 32'd1);
        checkOutput("single_writeEN_after", 32'(ctrl_writeEN), 32'd0);

        // A and B together: A first, B next; query tracks register 4.
        query_reg = 5'd4;
        applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(negedge clock); #1;
        checkOutput("pair_first_reg", 32'(ctrl_writeReg), 32'd3);
        checkOutput("pair_count", 32'(count), 32'd2);
        checkOutput("pair_query_n1", 32'(query_pending), 32'd1);
        @(negedge clock); #1;
        checkOutput("pair_second_reg", 32'(ctrl_writeReg), 32'd4);
        checkOutput("pair_second_data", data_writeReg, 32'h22);
        checkOutput("pair_query_n2", 32'(query_pending), 32'd1);
        @(negedge clock); #1;
        checkOutput("pair_query_after", 32'(query_pending), 32'd0);
        checkOutput("pair_empty_after", 32'(empty), 32'd1);
        query_reg = 5'd0;

        // Both ports continuously valid with registers 1..9.
        next_reg = 1;
        for (int it = 0; it < 30 && next_reg <= 9; it++) begin
            @(posedge clock); #1;
            a_valid = 1; a_reg = 5'(next_reg); a_data = 32'h100 + 32'(next_reg);
            b_valid = (next_reg + 1 <= 9);
            b_reg   = b_valid ? 5'(next_reg + 1) : 5'd0;
            b_data  = 32'h100 + 32'(next_reg + 1);
            #1;
            if (it == 0) checkOutput("fill_b_ready_empty", 32'(b_ready), 32'd1);
            if (it == 2) begin
                checkOutput("fill_count_3", 32'(count), 32'd3);
                checkOutput("fill_a_ready_free1", 32'(a_ready), 32'd1);
                checkOutput("fill_b_ready_free1", 32'(b_ready), 32'd0);
            end
            if (a_ready) begin
                next_reg++;
                if (b_valid && b_ready) next_reg++;
            end
        end
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        repeat (6) @(posedge clock);
        #1 checkOutput("fill_drained", 32'(empty), 32'd1);

        // Register 0 on A with B at free=1: both consumed, only B stored.
        applyStimulus(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
        applyStimulus(1, 5'd12, 32'hA1, 1, 5'd13, 32'hB1);
        applyStimulus(1, 5'd0, 32'hBAD, 1, 5'd7, 32'h77);
        #1;
        checkOutput("r0_count_before", 32'(count), 32'd3);
        checkOutput("r0_a_ready", 32'(a_ready), 32'd1);
        checkOutput("r0_b_ready", 32'(b_ready), 32'd1);
        checkOutput("r0_query0", 32'(query_pending), 32'd0);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        #1;
        checkOutput("r0_count_after", 32'(count), 32'd3);
        checkOutput("r0_head", 32'(ctrl_writeReg), 32'd12);
        repeat (5) @(posedge clock);

        // Steady one-in/one-out for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 5'((i % 31) + 1), 32'(i * 3), 0, 5'd0, 32'd0);
            if (i == 10) begin
                #1;
                checkOutput("steady_count", 32'(count), 32'd1);
                checkOutput("steady_head_reg", 32'(ctrl_writeReg), 32'd10);
                checkOutput("steady_head_data", data_writeReg, 32'd27);
            end
        end
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        repeat (3) @(posedge clock);

        // Asynchronous reset with three entries queued.
        applyStimulus(1, 5'd20, 32'h20, 1, 5'd21, 32'h21);
        applyStimulus(1, 5'd22, 32'h22, 1, 5'd23, 32'h23);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        #1 checkOutput("async_count_before", 32'(count), 32'd3);
        #1 ctrl_reset = 1'b1;
        #1;
        checkOutput("async_count", 32'(count), 32'd0);
        checkOutput("async_writeEN", 32'(ctrl_writeEN), 32'd0);
        checkOutput("async_empty", 32'(empty), 32'd1);
        @(posedge clock);
        #1 ctrl_reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 checkOutput("async_stays_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
